// File: rtl/pifo_reg_store.sv
// pifo_reg_store: register-based PIFO entry store.
// The store holds up to REG_WIDTH (rank, meta) entries and presents them flat
// to an external combinational min-reduction tree. The tree root index comes
// back on min_idx_in and selects the entry to dequeue.
// Optional feature: define PIFO_REG_STATS_EN to build the saturating 32-bit
// dropped-insert counter on drop_cnt. Without it, drop_cnt is tied to zero.
module pifo_reg_store #(
  parameter int REG_WIDTH  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int META_WIDTH = 10,
  parameter int IDX_WIDTH  = 2,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ins_en,
  input  logic [DATA_WIDTH-1:0]            ins_rank,
  input  logic [META_WIDTH-1:0]            ins_meta,
  input  logic                             rem_en,
  input  logic [IDX_WIDTH-1:0]             min_idx_in,
  output logic [REG_WIDTH*DATA_WIDTH-1:0]  data_flat,
  output logic [REG_WIDTH*META_WIDTH-1:0]  meta_flat,
  output logic [REG_WIDTH*IDX_WIDTH-1:0]   idx_flat,
  output logic [REG_WIDTH-1:0]             vld_flat,
  output logic [DATA_WIDTH-1:0]            deq_rank,
  output logic [META_WIDTH-1:0]            deq_meta,
  output logic                             deq_vld,
  output logic                             full,
  output logic                             empty,
  output logic [CNT_WIDTH-1:0]             count,
  output logic [31:0]                      drop_cnt
);

  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(REG_WIDTH);

  logic [DATA_WIDTH-1:0] rank_q [REG_WIDTH];
  logic [DATA_WIDTH-1:0] rank_d [REG_WIDTH];
  logic [META_WIDTH-1:0] meta_q [REG_WIDTH];
  logic [META_WIDTH-1:0] meta_d [REG_WIDTH];
  logic [REG_WIDTH-1:0]  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] deq_rank_q, deq_rank_d;
  logic [META_WIDTH-1:0] deq_meta_q, deq_meta_d;
  logic                  deq_vld_q, deq_vld_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;

  logic                  rem_acc;
  logic                  ins_acc;
  logic [IDX_WIDTH-1:0]  free_idx;
  logic [IDX_WIDTH-1:0]  tgt_idx;

  assign rem_acc = rem_en & ~empty_q;
  assign ins_acc = ins_en & (~full_q | rem_acc);

  // The tree sees slot registers directly; the slot index fields are constant.
  for (genvar g = 0; g < REG_WIDTH; g++) begin : g_flat
    assign data_flat[g*DATA_WIDTH +: DATA_WIDTH] = rank_q[g];
    assign meta_flat[g*META_WIDTH +: META_WIDTH] = meta_q[g];
    assign idx_flat[g*IDX_WIDTH +: IDX_WIDTH]    = IDX_WIDTH'(g);
  end

  assign vld_flat = vld_q;
  assign deq_rank = deq_rank_q;
  assign deq_meta = deq_meta_q;
  assign deq_vld  = deq_vld_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;

  // Pick the lowest free slot from start-of-cycle valid bits; when full, reuse the slot being removed.
  always_comb begin
    free_idx = '0;
    for (int i = REG_WIDTH - 1; i >= 0; i--) begin
      if (!vld_q[i]) free_idx = IDX_WIDTH'(i);
    end
    tgt_idx = full_q ? min_idx_in : free_idx;
  end

  // Next-state for slots, dequeue outputs and occupancy; removal is applied before insertion.
  always_comb begin
    rank_d     = rank_q;
    meta_d     = meta_q;
    vld_d      = vld_q;
    deq_rank_d = deq_rank_q;
    deq_meta_d = deq_meta_q;
    deq_vld_d  = rem_acc;
    if (rem_acc) begin
      vld_d[min_idx_in] = 1'b0;
      deq_rank_d        = rank_q[min_idx_in];
      deq_meta_d        = meta_q[min_idx_in];
    end
    if (ins_acc) begin
      rank_d[tgt_idx] = ins_rank;
      meta_d[tgt_idx] = ins_meta;
      vld_d[tgt_idx]  = 1'b1;
    end
    count_d = count_q + CNT_WIDTH'(ins_acc) - CNT_WIDTH'(rem_acc);
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
  end

  // State register; reset discards any same-cycle insert or remove.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_WIDTH; i++) begin
        rank_q[i] <= '0;
        meta_q[i] <= '0;
      end
      vld_q      <= '0;
      deq_rank_q <= '0;
      deq_meta_q <= '0;
      deq_vld_q  <= 1'b0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      for (int i = 0; i < REG_WIDTH; i++) begin
        rank_q[i] <= rank_d[i];
        meta_q[i] <= meta_d[i];
      end
      vld_q      <= vld_d;
      deq_rank_q <= deq_rank_d;
      deq_meta_q <= deq_meta_d;
      deq_vld_q  <= deq_vld_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
    end
  end

`ifdef PIFO_REG_STATS_EN
  logic [31:0] drop_cnt_q;
  logic        drop;

  assign drop     = ins_en & full_q & ~rem_acc;
  assign drop_cnt = drop_cnt_q;

  // Count inserts rejected because the store was full, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 32'hFFFF_FFFF)) begin
      drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end
`else
  assign drop_cnt = '0;
`endif

endmodule
